// File: rtl/l2_sim_pkg.sv
// Shared op/command/state encodings for the L2 request arbiter slice.
// Latency: n/a (types and pure helper functions only).
// Backpressure: n/a.
package l2_sim_pkg;

    typedef enum logic [1:0] {
        L1_DREAD   = 2'd0,
        L1_DWRITE  = 2'd1,
        L1_IREAD   = 2'd2,
        L1_ILLEGAL = 2'd3
    } l1_op_e;

    typedef enum logic [1:0] {
        SNP_INV   = 2'd0,
        SNP_READ  = 2'd1,
        SNP_WRITE = 2'd2,
        SNP_RWIM  = 2'd3
    } snp_op_e;

    typedef enum logic {
        MAINT_CLEAR = 1'b0,
        MAINT_PRINT = 1'b1
    } maint_op_e;

    // Trace codes seen by the L2 core; 7 is deliberately unused.
    typedef enum logic [3:0] {
        CMD_L1_DREAD  = 4'd0,
        CMD_L1_DWRITE = 4'd1,
        CMD_L1_IREAD  = 4'd2,
        CMD_SNP_INV   = 4'd3,
        CMD_SNP_READ  = 4'd4,
        CMD_SNP_WRITE = 4'd5,
        CMD_SNP_RWIM  = 4'd6,
        CMD_CLEAR     = 4'd8,
        CMD_PRINT     = 4'd9
    } cache_cmd_e;

    typedef enum logic [1:0] {
        ST_E_IDLE  = 2'd0,
        ST_E_ISSUE = 2'd1,
        ST_E_BUSY  = 2'd2
    } arb_state_e;

    // Snoop ops occupy trace codes 3..6.
    function automatic logic [3:0] snp_cmd(input logic [1:0] op);
        return 4'(CMD_SNP_INV) + {2'b00, op};
    endfunction

    // Maintenance ops occupy trace codes 8..9.
    function automatic logic [3:0] maint_cmd(input logic op);
        return {3'b100, op};
    endfunction

endpackage

// File: rtl/l2_request_arbiter_if.sv
// Request/command bundle between the three requestors, the arbiter and the L2 core.
// Latency: n/a (wiring only).
// Backpressure: valid/ready per requestor, cache_ready/cache_done from the core.
interface l2_request_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) ();

    logic              l1_valid;
    logic [1:0]        l1_op;
    logic [ADDR_W-1:0] l1_addr;
    logic              l1_ready;

    logic              snp_valid;
    logic [1:0]        snp_op;
    logic [ADDR_W-1:0] snp_addr;
    logic              snp_ready;

    logic              maint_valid;
    logic              maint_op;
    logic              maint_ready;

    logic              cache_valid;
    logic [3:0]        cache_cmd;
    logic [ADDR_W-1:0] cache_addr;
    logic              cache_ready;
    logic              cache_done;

    logic              busy;
    logic [CNT_W-1:0]  l1_grants;
    logic [CNT_W-1:0]  snp_grants;

    // Arbiter side.
    modport slave (
        input  l1_valid, l1_op, l1_addr,
        input  snp_valid, snp_op, snp_addr,
        input  maint_valid, maint_op,
        input  cache_ready, cache_done,
        output l1_ready, snp_ready, maint_ready,
        output cache_valid, cache_cmd, cache_addr,
        output busy, l1_grants, snp_grants
    );

    // Requestor / L2 core side.
    modport master (
        output l1_valid, l1_op, l1_addr,
        output snp_valid, snp_op, snp_addr,
        output maint_valid, maint_op,
        output cache_ready, cache_done,
        input  l1_ready, snp_ready, maint_ready,
        input  cache_valid, cache_cmd, cache_addr,
        input  busy, l1_grants, snp_grants
    );

endinterface

// File: rtl/l2_req_prio_arb.sv
// Fixed-priority maint > snoop > L1 picker with an L1 anti-starvation override.
// Latency: combinational grant; starvation count updates on the grant edge.
// Backpressure: grants only while arb_en is high and reset is low.
module l2_req_prio_arb #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic arb_en,
    input  logic l1_valid,
    input  logic snp_valid,
    input  logic maint_valid,
    input  logic starve_clr,
    output logic l1_ready,
    output logic snp_ready,
    output logic maint_ready
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    logic [SW-1:0] starve_cnt;
    logic          arb_open;
    logic          starved;

    assign arb_open = arb_en & ~reset;
    assign starved  = (starve_cnt == LIMIT);

    // Single winner; a starved L1 request jumps ahead of snoops but never maintenance.
    always_comb begin
        maint_ready = 1'b0;
        snp_ready   = 1'b0;
        l1_ready    = 1'b0;
        if (arb_open) begin
            if (maint_valid) begin
                maint_ready = 1'b1;
            end else if (l1_valid && starved) begin
                l1_ready = 1'b1;
            end else if (snp_valid) begin
                snp_ready = 1'b1;
            end else if (l1_valid) begin
                l1_ready = 1'b1;
            end
        end
    end

    // Count snoop wins that happened while L1 was waiting, saturating at the limit.
    always_ff @(posedge clock) begin
        if (reset || starve_clr) begin
            starve_cnt <= '0;
        end else if (l1_ready) begin
            starve_cnt <= '0;
        end else if (snp_ready) begin
            if (!l1_valid) begin
                starve_cnt <= '0;
            end else if (!starved) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
        end
    end

endmodule

// File: rtl/l2_request_arbiter.sv
// Arbitrates L1, snoop and maintenance requests into a single L2 core command slot.
// Latency: accept in cycle N -> cache_valid in N+1; min 3 cycles per command.
// Backpressure: one command outstanding; no requestor is readied until the core signals done.
module l2_request_arbiter
    import l2_sim_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 16
) (
    input  logic                clock,
    input  logic                reset,
    l2_request_arbiter_if.slave bus
);

    localparam logic [1:0] ST_IDLE  = ST_E_IDLE;
    localparam logic [1:0] ST_ISSUE = ST_E_ISSUE;
    localparam logic [1:0] ST_BUSY  = ST_E_BUSY;

    logic [1:0]        state;
    logic [3:0]        cmd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  l1_cnt;
    logic [CNT_W-1:0]  snp_cnt;

    logic arb_en;
    logic l1_rdy;
    logic snp_rdy;
    logic maint_rdy;
    logic l1_take;
    logic clear_done;

    assign arb_en     = (state == ST_IDLE);
    // An illegal L1 op is handshaken away but never becomes a command.
    assign l1_take    = l1_rdy & (bus.l1_op != L1_ILLEGAL);
    assign clear_done = (state == ST_BUSY) & bus.cache_done & (cmd_q == CMD_CLEAR);

    l2_req_prio_arb #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio_arb (
        .clock       (clock),
        .reset       (reset),
        .arb_en      (arb_en),
        .l1_valid    (bus.l1_valid),
        .snp_valid   (bus.snp_valid),
        .maint_valid (bus.maint_valid),
        .starve_clr  (clear_done),
        .l1_ready    (l1_rdy),
        .snp_ready   (snp_rdy),
        .maint_ready (maint_rdy)
    );

    // Command slot FSM: latch the winner, hold it until the core takes it, wait for done.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= ST_IDLE;
            cmd_q  <= '0;
            addr_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (maint_rdy) begin
                        cmd_q  <= maint_cmd(bus.maint_op);
                        addr_q <= '0;
                        state  <= ST_ISSUE;
                    end else if (snp_rdy) begin
                        cmd_q  <= snp_cmd(bus.snp_op);
                        addr_q <= bus.snp_addr;
                        state  <= ST_ISSUE;
                    end else if (l1_take) begin
                        cmd_q  <= {2'b00, bus.l1_op};
                        addr_q <= bus.l1_addr;
                        state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (bus.cache_ready) begin
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (bus.cache_done) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Saturating grant statistics, wiped when a clear command completes.
    always_ff @(posedge clock) begin
        if (reset || clear_done) begin
            l1_cnt  <= '0;
            snp_cnt <= '0;
        end else begin
            if (l1_take && (l1_cnt != '1)) begin
                l1_cnt <= l1_cnt + CNT_W'(1);
            end
            if (snp_rdy && (snp_cnt != '1)) begin
                snp_cnt <= snp_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.l1_ready    = l1_rdy;
    assign bus.snp_ready   = snp_rdy;
    assign bus.maint_ready = maint_rdy;
    assign bus.cache_valid = (state == ST_ISSUE);
    assign bus.cache_cmd   = cmd_q;
    assign bus.cache_addr  = addr_q;
    assign bus.busy        = (state != ST_IDLE);
    assign bus.l1_grants   = l1_cnt;
    assign bus.snp_grants  = snp_cnt;

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Directed bench for l2_request_arbiter with an expected-command scoreboard.
// Latency: n/a.
// Backpressure: the core model drives cache_done one cycle after each taken command.
module tb_l2_request_arbiter;

    logic clk;
    logic rst;
    logic done_en;
    logic hs_prev;
    int   npass;
    int   ntotal;
    logic [35:0] exp_q[$];

    l2_request_arbiter_if #(.ADDR_W(32), .CNT_W(16)) bus ();

    l2_request_arbiter #(
        .ADDR_W       (32),
        .STARVE_LIMIT (4),
        .CNT_W        (16)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Hold valids until each requestor's ready has been seen once.
    task automatic serve(input string tag, input int max_cyc);
        logic lr, sr, mr;
        int n = 0;
        while ((bus.l1_valid || bus.snp_valid || bus.maint_valid) && n < max_cyc) begin
            @(negedge clk);
            lr = bus.l1_ready;
            sr = bus.snp_ready;
            mr = bus.maint_ready;
            @(posedge clk); #1;
            if (lr) bus.l1_valid = 1'b0;
            if (sr) bus.snp_valid = 1'b0;
            if (mr) bus.maint_valid = 1'b0;
            n++;
        end
        check(tag, 64'({bus.l1_valid, bus.snp_valid, bus.maint_valid}), 64'(0));
    endtask

    // Wait until every expected command has been seen and the arbiter is idle.
    task automatic drain(input string tag);
        int n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.busy) break;
            n++;
        end
        check(tag, 64'({bus.busy, exp_q.size() != 0}), 64'(0));
        @(posedge clk); #1;
    endtask

    // L2 core model: scoreboard on command handshake, done one cycle later.
    initial begin : core_model
        logic [35:0] e;
        logic [2:0]  r;
        logic [2:0]  v;
        hs_prev = 1'b0;
        bus.cache_done = 1'b0;
        forever begin
            @(negedge clk);
            bus.cache_done = hs_prev & done_en;
            hs_prev = bus.cache_valid & bus.cache_ready & ~rst;
            r = {bus.maint_ready, bus.snp_ready, bus.l1_ready};
            v = {bus.maint_valid, bus.snp_valid, bus.l1_valid};
            check("rdy_excl", 64'(($countones(r) <= 1) && ((r & ~v) == 3'b000)), 64'(1));
            if (hs_prev) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_cmd", 64'(bus.cache_cmd), 64'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_cmd", 64'(bus.cache_cmd), 64'(e[35:32]));
                    check("sb_addr", 64'(bus.cache_addr), 64'(e[31:0]));
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [3:0] rdy_hist, vld_hist, busy_hist;
        logic [15:0] g;
        int sc, lc;
        npass = 0;
        ntotal = 0;
        done_en = 1'b1;
        rst = 1'b1;
        bus.l1_valid = 1'b1;   bus.l1_op = 2'd0;  bus.l1_addr = 32'h0;
        bus.snp_valid = 1'b1;  bus.snp_op = 2'd0; bus.snp_addr = 32'h0;
        bus.maint_valid = 1'b1; bus.maint_op = 1'b0;
        bus.cache_ready = 1'b1;

        // Reset: no ready even with every requestor valid.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_readies", 64'({bus.maint_ready, bus.snp_ready, bus.l1_ready}), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        bus.l1_valid = 1'b0; bus.snp_valid = 1'b0; bus.maint_valid = 1'b0;
        @(negedge clk);
        check("rst_cache_valid", 64'(bus.cache_valid), 64'(0));
        check("rst_cache_cmd", 64'(bus.cache_cmd), 64'(0));
        check("rst_cache_addr", 64'(bus.cache_addr), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_l1_grants", 64'(bus.l1_grants), 64'(0));
        check("rst_snp_grants", 64'(bus.snp_grants), 64'(0));
        @(posedge clk); #1;

        // L1 data write held valid: accepts at cycles 0 and 3.
        exp_q.push_back({4'd1, 32'h1000});
        exp_q.push_back({4'd1, 32'h1000});
        bus.l1_valid = 1'b1; bus.l1_op = 2'd1; bus.l1_addr = 32'h1000;
        g = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            rdy_hist[c]  = bus.l1_ready;
            vld_hist[c]  = bus.cache_valid;
            busy_hist[c] = bus.busy;
            if (c == 3) g = bus.l1_grants;
            @(posedge clk); #1;
        end
        bus.l1_valid = 1'b0;
        check("t1_ready_spacing", 64'(rdy_hist), 64'(4'b1001));
        check("t1_cache_valid", 64'(vld_hist), 64'(4'b0010));
        check("t1_busy", 64'(busy_hist), 64'(4'b0110));
        check("t1_l1_grants_first", 64'(g), 64'(1));
        drain("t1_drain");
        check("t1_l1_grants", 64'(bus.l1_grants), 64'(2));

        // Simultaneous snoop RWIM and L1 data read: snoop wins.
        exp_q.push_back({4'd6, 32'h2000});
        exp_q.push_back({4'd0, 32'h3000});
        bus.snp_valid = 1'b1; bus.snp_op = 2'd3; bus.snp_addr = 32'h2000;
        bus.l1_valid = 1'b1;  bus.l1_op = 2'd0;  bus.l1_addr = 32'h3000;
        serve("t2_serve", 30);
        drain("t2_drain");
        check("t2_snp_grants", 64'(bus.snp_grants), 64'(1));
        check("t2_l1_grants", 64'(bus.l1_grants), 64'(3));

        // Continuous snoop pressure: 4 snoops then 1 L1, twice.
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 4; j++) exp_q.push_back({4'd4, 32'h4000});
            exp_q.push_back({4'd2, 32'h5000});
        end
        bus.snp_valid = 1'b1; bus.snp_op = 2'd1; bus.snp_addr = 32'h4000;
        bus.l1_valid = 1'b1;  bus.l1_op = 2'd2;  bus.l1_addr = 32'h5000;
        sc = 0;
        lc = 0;
        for (int c = 0; c < 60 && lc < 2; c++) begin
            @(negedge clk);
            if (bus.snp_ready) sc++;
            if (bus.l1_ready) lc++;
            @(posedge clk); #1;
        end
        bus.snp_valid = 1'b0;
        bus.l1_valid = 1'b0;
        check("t3_snp_count", 64'(sc), 64'(8));
        check("t3_l1_count", 64'(lc), 64'(2));
        drain("t3_drain");
        check("t3_snp_grants", 64'(bus.snp_grants), 64'(9));
        check("t3_l1_grants", 64'(bus.l1_grants), 64'(5));

        // Maintenance clear wipes both grant counters on completion.
        exp_q.push_back({4'd8, 32'h0});
        bus.maint_valid = 1'b1; bus.maint_op = 1'b0;
        serve("t4_serve", 10);
        drain("t4_drain");
        check("t4_l1_grants", 64'(bus.l1_grants), 64'(0));
        check("t4_snp_grants", 64'(bus.snp_grants), 64'(0));

        // All three at once: print, then snoop invalidate, then L1 instr read.
        exp_q.push_back({4'd9, 32'h0});
        exp_q.push_back({4'd3, 32'h6000});
        exp_q.push_back({4'd2, 32'h7000});
        bus.maint_valid = 1'b1; bus.maint_op = 1'b1;
        bus.snp_valid = 1'b1;   bus.snp_op = 2'd0; bus.snp_addr = 32'h6000;
        bus.l1_valid = 1'b1;    bus.l1_op = 2'd2;  bus.l1_addr = 32'h7000;
        serve("t5_serve", 30);
        drain("t5_drain");
        check("t5_l1_grants", 64'(bus.l1_grants), 64'(1));
        check("t5_snp_grants", 64'(bus.snp_grants), 64'(1));

        // Core stalls in ISSUE for 5 cycles, then reset lands while BUSY.
        bus.cache_ready = 1'b0;
        exp_q.push_back({4'd5, 32'h8000});
        bus.snp_valid = 1'b1; bus.snp_op = 2'd2; bus.snp_addr = 32'h8000;
        @(negedge clk);
        check("t6_snp_ready", 64'(bus.snp_ready), 64'(1));
        @(posedge clk); #1;
        bus.snp_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t6_hold_valid", 64'(bus.cache_valid), 64'(1));
            check("t6_hold_cmd", 64'(bus.cache_cmd), 64'(5));
            check("t6_hold_addr", 64'(bus.cache_addr), 64'(32'h8000));
            @(posedge clk); #1;
        end
        done_en = 1'b0;
        bus.cache_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        bus.cache_ready = 1'b0;
        @(negedge clk);
        check("t6_busy_before_rst", 64'(bus.busy), 64'(1));
        check("t6_snp_grants", 64'(bus.snp_grants), 64'(2));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("t6_rst_busy", 64'(bus.busy), 64'(0));
        check("t6_rst_cache_valid", 64'(bus.cache_valid), 64'(0));
        check("t6_rst_cmd", 64'(bus.cache_cmd), 64'(0));
        check("t6_rst_addr", 64'(bus.cache_addr), 64'(0));
        check("t6_rst_grants", 64'({bus.l1_grants, bus.snp_grants}), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        done_en = 1'b1;
        bus.cache_ready = 1'b1;

        // Illegal L1 op: handshaken and dropped.
        bus.l1_valid = 1'b1; bus.l1_op = 2'd3; bus.l1_addr = 32'h9000;
        @(negedge clk);
        check("t7_l1_ready", 64'(bus.l1_ready), 64'(1));
        @(posedge clk); #1;
        bus.l1_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t7_no_cmd", 64'({bus.cache_valid, bus.busy}), 64'(0));
            @(posedge clk); #1;
        end
        check("t7_l1_grants", 64'(bus.l1_grants), 64'(0));

        // Normal L1 traffic resumes after reset with no replayed command.
        exp_q.push_back({4'd0, 32'hA000});
        bus.l1_valid = 1'b1; bus.l1_op = 2'd0; bus.l1_addr = 32'hA000;
        serve("t8_serve", 10);
        drain("t8_drain");
        check("t8_l1_grants", 64'(bus.l1_grants), 64'(1));
        check("sb_empty", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
